// File: rtl/cachepool_boot_seq.sv
// cachepool_boot_seq: writes the entry point to each enabled cluster, wakes the cores and collects EOC
module cachepool_boot_seq #(
   parameter int unsigned          NumClusters     = 1,
   parameter int unsigned          AddrWidth       = 48,
   parameter int unsigned          DataWidth       = 32,
   parameter logic [AddrWidth-1:0] PeriBase        = 48'h0000_5100_0000,
   parameter logic [AddrWidth-1:0] ClusterStride   = 48'h0000_0100_0000,
   parameter logic [AddrWidth-1:0] BootOffset      = 48'h0000_0000_0058,
   parameter int unsigned          WakePulseCycles = 1,
   parameter int unsigned          CntWidth        = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [31:0]            entry_point_i,
   input  logic [NumClusters-1:0] cluster_mask_i,
   input  logic [CntWidth-1:0]    timeout_i,
   output logic                   q_valid_o,
   input  logic                   q_ready_i,
   output logic [AddrWidth-1:0]   q_addr_o,
   output logic [DataWidth-1:0]   q_data_o,
   output logic                   q_write_o,
   output logic [DataWidth/8-1:0] q_strb_o,
   input  logic                   p_valid_i,
   output logic                   p_ready_o,
   input  logic                   p_error_i,
   output logic [NumClusters-1:0] debug_req_o,
   input  logic [NumClusters-1:0] eoc_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o,
   output logic                   timeout_o,
   output logic [NumClusters-1:0] eoc_seen_o,
   output logic [CntWidth-1:0]    cycles_o
);
   localparam int unsigned WakeW = $clog2(WakePulseCycles + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, RESP, WAKE, WAIT_EOC, DONE} state_e;

   state_e                 state, state_next;
   logic [NumClusters-1:0] mask, remaining, lowest, eoc_seen, seen_next;
   logic [31:0]            entry;
   logic [CntWidth-1:0]    timeout, cycles;
   logic [WakeW-1:0]       wake_cnt;
   logic [AddrWidth-1:0]   idx;
   logic                   error, timed_out, start_ok, busy, all_seen, expired;

   assign start_ok   = start_i && (state == IDLE || state == DONE);
   assign busy       = state inside {ISSUE, RESP, WAKE, WAIT_EOC};
   assign lowest     = remaining & (~remaining + 1'b1);
   assign seen_next  = eoc_seen | (eoc_i & mask);
   assign all_seen   = (seen_next & mask) == mask;
   assign expired    = timeout != '0 && (cycles + 1'b1) == timeout;
   assign busy_o     = busy;
   assign done_o     = state == DONE;
   assign error_o    = error;
   assign timeout_o  = timed_out;
   assign eoc_seen_o = eoc_seen;
   assign cycles_o   = cycles;

   // index of the lowest cluster still waiting for its boot write
   always_comb begin
      idx = '0;
      for (int i = NumClusters - 1; i >= 0; i--)
         if (remaining[i]) idx = AddrWidth'(i);
   end

   // state register
   always_ff @(posedge clk_i) begin
      state <= !rst_ni ? IDLE : state_next;
   end

   // next-state and reqrsp / wake outputs; only state-held values reach the ports
   always_comb begin
      state_next  = state;
      q_valid_o   = 1'b0;
      q_addr_o    = '0;
      q_data_o    = '0;
      q_write_o   = 1'b0;
      q_strb_o    = '0;
      p_ready_o   = 1'b0;
      debug_req_o = '0;
      unique case (state)
         IDLE, DONE: if (start_i) state_next = (cluster_mask_i == '0) ? DONE : ISSUE;
         ISSUE: begin
            q_valid_o = 1'b1;
            q_addr_o  = PeriBase + idx * ClusterStride + BootOffset;
            q_data_o  = DataWidth'(entry);
            q_write_o = 1'b1;
            q_strb_o  = '1;
            if (q_ready_i) state_next = RESP;
         end
         RESP: begin
            p_ready_o = 1'b1;
            if (p_valid_i) state_next = p_error_i ? DONE : (remaining != '0 ? ISSUE : WAKE);
         end
         WAKE: begin
            debug_req_o = mask;
            if (wake_cnt == WakeW'(WakePulseCycles - 1)) state_next = WAIT_EOC;
         end
         WAIT_EOC: if (all_seen || expired) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // sampled configuration, remaining mask, sticky flags and counters
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mask      <= '0;
         remaining <= '0;
         entry     <= '0;
         timeout   <= '0;
         eoc_seen  <= '0;
         cycles    <= '0;
         wake_cnt  <= '0;
         error     <= 1'b0;
         timed_out <= 1'b0;
      end else begin
         wake_cnt <= (state == WAKE) ? wake_cnt + 1'b1 : '0;
         if (start_ok) begin
            mask      <= cluster_mask_i;
            remaining <= cluster_mask_i;
            entry     <= entry_point_i;
            timeout   <= timeout_i;
            eoc_seen  <= '0;
            cycles    <= '0;
            error     <= 1'b0;
            timed_out <= 1'b0;
         end else begin
            if (busy) eoc_seen <= seen_next;
            if (state == ISSUE && q_ready_i) remaining <= remaining & ~lowest;
            if (state == RESP && p_valid_i && p_error_i) error <= 1'b1;
            if (state == WAIT_EOC && !(&cycles)) cycles <= cycles + 1'b1;
            if (state == WAIT_EOC && !all_seen && expired) timed_out <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_cachepool_boot_seq.sv
// tb_cachepool_boot_seq: table-driven and randomized checks of the boot sequencer against a behavioural model
module tb_cachepool_boot_seq;
   localparam int N = 4;
   localparam int WP = 2;
   localparam logic [47:0] BASE = 48'h0000_5100_0000;
   localparam logic [47:0] STRIDE = 48'h0000_0100_0000;
   localparam logic [47:0] OFF = 48'h0000_0000_0058;
   localparam logic [7:0] KN = 8'd0;
   localparam logic [7:0] KW = 8'd255;

   // k per cluster: KN = no EOC, KW = pulse in first wake cycle, else WAIT_EOC cycle number
   typedef struct packed {
      logic [N-1:0]      mask;
      logic [31:0]       entry;
      logic [31:0]       tmo;
      int                err_k;
      int                qdly;
      int                pdly;
      logic [N-1:0][7:0] k;
      logic              exp_err;
      logic              exp_tmo;
      logic [31:0]       exp_cyc;
      logic [N-1:0]      exp_seen;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, q_ready = 1'b0, p_valid = 1'b0, p_error = 1'b0;
   logic [31:0] entry = '0, tmo = '0;
   logic [N-1:0] cmask = '0, eoc = '0;
   logic q_valid_o, q_write_o, p_ready_o, busy_o, done_o, error_o, timeout_o;
   logic [47:0] q_addr_o;
   logic [31:0] q_data_o, cycles_o;
   logic [3:0] q_strb_o;
   logic [N-1:0] debug_req_o, eoc_seen_o;
   int tests = 0, fails = 0;

   cachepool_boot_seq #(.NumClusters(N), .WakePulseCycles(WP)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .entry_point_i(entry),
      .cluster_mask_i(cmask), .timeout_i(tmo), .q_valid_o(q_valid_o), .q_ready_i(q_ready),
      .q_addr_o(q_addr_o), .q_data_o(q_data_o), .q_write_o(q_write_o), .q_strb_o(q_strb_o),
      .p_valid_i(p_valid), .p_ready_o(p_ready_o), .p_error_i(p_error), .debug_req_o(debug_req_o),
      .eoc_i(eoc), .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .timeout_o(timeout_o),
      .eoc_seen_o(eoc_seen_o), .cycles_o(cycles_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [N-1:0] mask, input logic [31:0] ent, input logic [31:0] to,
                               input int err_k, input int qdly, input int pdly,
                               input logic [7:0] k3, input logic [7:0] k2, input logic [7:0] k1, input logic [7:0] k0,
                               input logic err, input logic tf, input logic [31:0] cyc, input logic [N-1:0] seen);
      vec_t v;
      v.mask = mask; v.entry = ent; v.tmo = to; v.err_k = err_k; v.qdly = qdly; v.pdly = pdly;
      v.k = {k3, k2, k1, k0};
      v.exp_err = err; v.exp_tmo = tf; v.exp_cyc = cyc; v.exp_seen = seen;
      return v;
   endfunction

   // completion cycle is the latest masked EOC (at least 1); a nonzero timeout earlier than that wins
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int c_done = 1;
      bit never = 0;
      r.exp_err = v.err_k < $countones(v.mask);
      r.exp_tmo = 0; r.exp_cyc = 0; r.exp_seen = 0;
      if (r.exp_err) return r;
      for (int c = 0; c < N; c++)
         if (v.mask[c]) begin
            if (v.k[c] == KN) never = 1;
            else if (v.k[c] != KW && int'(v.k[c]) > c_done) c_done = int'(v.k[c]);
         end
      if (v.tmo != 0 && (never || int'(v.tmo) < c_done)) begin
         r.exp_tmo = 1;
         r.exp_cyc = v.tmo;
         for (int c = 0; c < N; c++)
            r.exp_seen[c] = v.mask[c] && (v.k[c] == KW || (v.k[c] != KN && int'(v.k[c]) <= int'(v.tmo)));
      end else begin
         r.exp_cyc = c_done;
         r.exp_seen = v.mask;
      end
      return r;
   endfunction

   task automatic run_case(input vec_t v, input string tag);
      logic [47:0] exp_addr[$];
      logic [47:0] hold_a;
      logic [31:0] hold_d;
      int nw = 0, nresp = 0, qwait = 0, pwait = 0, wake_len = 0, w = 0, budget = 0;
      bit unstable = 0, bad_wake = 0, held = 0;
      for (int c = 0; c < N; c++)
         if (v.mask[c] && exp_addr.size() <= v.err_k) exp_addr.push_back(BASE + 48'(c) * STRIDE + OFF);
      cmask = v.mask; entry = v.entry; tmo = v.tmo; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " q_valid_first"}, q_valid_o, 1);
      check({tag, " restart_clear"}, {error_o, timeout_o, eoc_seen_o, cycles_o}, 0);
      while (!done_o && budget < 1000) begin
         if (q_valid_o) begin
            if (held && (q_addr_o !== hold_a || q_data_o !== hold_d)) unstable = 1;
            if (q_write_o !== 1'b1 || q_strb_o !== 4'hF) unstable = 1;
            hold_a = q_addr_o; hold_d = q_data_o; held = 1;
            q_ready = (qwait >= v.qdly);
            qwait++;
            if (q_ready) begin
               if (nw < exp_addr.size()) check({tag, " addr"}, q_addr_o, exp_addr[nw]);
               check({tag, " data"}, q_data_o, v.entry);
               nw++; qwait = 0; held = 0;
            end
         end else q_ready = 1'b0;
         if (p_ready_o) begin
            p_valid = (pwait >= v.pdly);
            p_error = p_valid && (nresp == v.err_k);
            if (p_valid) begin nresp++; pwait = 0; end else pwait++;
         end else begin
            p_valid = 1'b0; p_error = 1'b0;
         end
         if (debug_req_o != '0) begin
            if (debug_req_o !== v.mask) bad_wake = 1;
            wake_len++;
         end else if (wake_len > 0 && busy_o) w++;
         for (int c = 0; c < N; c++)
            eoc[c] = (v.k[c] == KW && debug_req_o != '0 && wake_len == 1) ||
                     (v.k[c] != KN && v.k[c] != KW && int'(v.k[c]) == w);
         @(negedge clk);
         budget++;
      end
      q_ready = 1'b0; p_valid = 1'b0; p_error = 1'b0; eoc = '0;
      check({tag, " done"}, done_o, 1);
      check({tag, " writes"}, nw, exp_addr.size());
      check({tag, " q_stable"}, unstable, 0);
      check({tag, " wake_len"}, wake_len, v.exp_err ? 0 : WP);
      check({tag, " wake_value"}, bad_wake, 0);
      check({tag, " error"}, error_o, v.exp_err);
      check({tag, " timeout"}, timeout_o, v.exp_tmo);
      check({tag, " cycles"}, cycles_o, v.exp_cyc);
      check({tag, " eoc_seen"}, eoc_seen_o, v.exp_seen);
      check({tag, " busy"}, busy_o, 0);
   endtask

   initial begin
      vec_t tbl[10];
      vec_t v;
      int r;
      tbl[0] = mk(4'b1010, 32'h8000_0000, 0,   99, 0, 0, 8'd9,  KN,    8'd5,   KN,    0, 0, 9,   4'b1010);
      tbl[1] = mk(4'b0001, 32'h1234_5678, 0,   99, 5, 1, KN,    KN,    KN,     8'd3,  0, 0, 3,   4'b0001);
      tbl[2] = mk(4'b1101, 32'hCAFE_0000, 0,   1,  0, 0, KN,    KN,    KN,     KN,    1, 0, 0,   4'b0000);
      tbl[3] = mk(4'b0011, 32'h0000_1000, 100, 99, 0, 0, KN,    KN,    KN,     KN,    0, 1, 100, 4'b0000);
      tbl[4] = mk(4'b0011, 32'h0000_2000, 100, 99, 1, 0, KN,    KN,    8'd100, 8'd20, 0, 0, 100, 4'b0011);
      tbl[5] = mk(4'b1010, 32'h8000_0000, 0,   99, 0, 0, 8'd7,  KN,    KW,     KN,    0, 0, 7,   4'b1010);
      tbl[6] = mk(4'b1111, 32'h4000_0040, 10,  99, 2, 2, 8'd11, 8'd10, KW,     8'd3,  0, 1, 10,  4'b0111);
      tbl[7] = mk(4'b1000, 32'h0BAD_0BAD, 0,   0,  0, 1, KN,    KN,    KN,     KN,    1, 0, 0,   4'b0000);
      tbl[8] = mk(4'b0100, 32'h0000_0004, 0,   99, 0, 0, 8'd1,  8'd2,  KN,     8'd1,  0, 0, 2,   4'b0100);
      tbl[9] = mk(4'b0110, 32'hFFFF_FFFC, 0,   99, 3, 0, KN,    KW,    KW,     KN,    0, 0, 1,   4'b0110);

      repeat (3) @(negedge clk);
      check("reset all_zero", |{q_valid_o, q_addr_o, q_data_o, q_write_o, q_strb_o, p_ready_o, debug_req_o,
                                busy_o, done_o, error_o, timeout_o, eoc_seen_o, cycles_o}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle busy_done", {busy_o, done_o}, 0);

      cmask = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("mask0 done", done_o, 1);
      check("mask0 q_valid", q_valid_o, 0);
      check("mask0 busy", busy_o, 0);
      @(negedge clk);
      check("mask0 debug_req", debug_req_o, 0);

      for (int i = 0; i < 10; i++) run_case(tbl[i], $sformatf("vec%0d", i));

      cmask = 4'b0100; entry = 32'hDEAD_BEEF; tmo = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      q_ready = 1'b1;
      for (int i = 0; i < 20 && !p_ready_o; i++) @(negedge clk);
      q_ready = 1'b0;
      check("rst_mid in_resp", p_ready_o, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid all_zero", |{q_valid_o, q_addr_o, q_data_o, q_write_o, q_strb_o, p_ready_o, debug_req_o,
                                  busy_o, done_o, error_o, timeout_o, eoc_seen_o, cycles_o}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid idle", {busy_o, done_o, q_valid_o, p_ready_o}, 0);

      for (int i = 0; i < 30; i++) begin
         v = '0;
         v.mask = 4'($urandom_range(1, 15));
         v.entry = $urandom;
         v.tmo = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
         v.err_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 99;
         v.qdly = int'($urandom_range(0, 3));
         v.pdly = int'($urandom_range(0, 2));
         for (int c = 0; c < N; c++) begin
            r = int'($urandom_range(0, 9));
            v.k[c] = (r == 0) ? KW : (r == 1 && v.tmo != 0) ? KN : 8'($urandom_range(1, 45));
         end
         run_case(model(v), $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
